// File: rtl/prog_load_pkg.sv
// Shared types and defaults for the program-load controller.
package prog_load_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int DEFAULT_ADDR_W  = 14;
  localparam int DEFAULT_TIMEOUT = 2_000_000;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream LSB-first into 32-bit words.
// Used for both the length prefix and the program data.
module byte_packer
  import prog_load_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane;

  // Insert each byte into its lane; flag a complete word the cycle after its last byte.
  // Every lane is overwritten before the next flag, so the word register is never cleared between words.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      lane       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && (lane == LAST_LANE);
      if (byte_valid) begin
        word[{lane, 3'b000} +: 8] <= byte_data;
        lane                      <= lane + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Program-load controller: holds the CPU in reset and streams a
// length-prefixed UART image into instruction memory from word 0.
module prog_load_ctrl
  import prog_load_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] cpu_imem_addr,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t            state;
  state_t            state_next;
  logic              start_q;
  logic              start_edge;
  logic [IDLE_W-1:0] idle_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [31:0]       pk_word;
  logic              pk_valid;
  logic              pk_clear;
  logic              pk_in_valid;
  logic              timeout_hit;
  logic              load_start;
  logic              finish_ok;
  logic              finish_err;

  assign start_edge  = start_pg & ~start_q;
  assign pk_clear    = (state == ST_RUN);
  assign pk_in_valid = rx_valid & (state != ST_RUN);
  assign timeout_hit = (state != ST_RUN) && !rx_valid && (idle_cnt == IDLE_LAST);
  assign imem_addr   = (state == ST_RUN) ? cpu_imem_addr : word_idx;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (pk_in_valid),
    .byte_data  (rx_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus one-cycle start/finish events for the datapath.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    case (state)
      ST_RUN: begin
        if (start_edge) begin
          state_next = ST_LEN;
          load_start = 1'b1;
        end
      end
      ST_LEN: begin
        if (timeout_hit) begin
          state_next = ST_RUN;
          finish_err = 1'b1;
        end else if (pk_valid) begin
          if (pk_word == 32'd0) begin
            state_next = ST_RUN;
            finish_ok  = 1'b1;
          end else if (pk_word > MAX_WORDS) begin
            state_next = ST_RUN;
            finish_err = 1'b1;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (imem_we && (word_idx == last_idx)) begin
          state_next = ST_RUN;
          finish_ok  = 1'b1;
        end else if (timeout_hit) begin
          state_next = ST_RUN;
          finish_err = 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Registered outputs, counters and the start-edge detector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q    <= 1'b0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      idle_cnt   <= '0;
      word_idx   <= '0;
      last_idx   <= '0;
    end else begin
      start_q   <= start_pg;
      cpu_rst_n <= load_start ? 1'b0 : (state_next == ST_RUN);
      busy      <= (state_next != ST_RUN);
      done      <= finish_ok;

      if (load_start) begin
        err <= 1'b0;
      end else if (finish_err) begin
        err <= 1'b1;
      end

      imem_we <= (state == ST_DATA) && pk_valid;
      if ((state == ST_DATA) && pk_valid) begin
        imem_wdata <= pk_word;
      end

      if ((state == ST_RUN) || rx_valid) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (load_start) begin
        word_idx <= '0;
      end else if (imem_we) begin
        word_idx <= word_idx + ADDR_W'(1);
      end

      if ((state == ST_LEN) && pk_valid) begin
        last_idx <= pk_word[ADDR_W-1:0] - ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed self-checking bench for prog_load_ctrl (ADDR_W=14, TIMEOUT=16).
module tb_prog_load_ctrl;

  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_pg;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] cpu_imem_addr;
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_we;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  int                wr_total   = 0;
  int                done_total = 0;
  int                rst_viol   = 0;
  logic [ADDR_W-1:0] wr_addr [0:63];
  logic [31:0]       wr_data [0:63];

  prog_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_pg      (start_pg),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .cpu_imem_addr (cpu_imem_addr),
    .cpu_rst_n     (cpu_rst_n),
    .imem_addr     (imem_addr),
    .imem_we       (imem_we),
    .imem_wdata    (imem_wdata),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Log every memory write and done pulse; flag any cycle where a load runs with the CPU released.
  always @(posedge clk) begin
    if (imem_we) begin
      if (wr_total < 64) begin
        wr_addr[wr_total] <= imem_addr;
        wr_data[wr_total] <= imem_wdata;
      end
      wr_total <= wr_total + 1;
    end
    if (done) done_total <= done_total + 1;
    if (busy && cpu_rst_n) rst_viol <= rst_viol + 1;
  end

  // Hard stop so a stuck run still reports.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic start_load();
    start_pg = 1'b1;
    @(negedge clk);
    start_pg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (cpu_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_rst_n: got %b expected 0", cpu_rst_n); end
    if (imem_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_imem_we: got %b expected 0", imem_we); end
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    if (imem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata: got %h expected 0", imem_wdata); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_rst_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_release: got %b expected 1", cpu_rst_n); end
  endtask

  task automatic test_basic_load();
    int wbase;
    int dbase;
    wbase = wr_total;
    dbase = done_total;
    start_load();
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    if (cpu_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL basic_cpu_hold: got %b expected 0", cpu_rst_n); end
    send_word(32'd2);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    @(negedge clk);
    checks += 4;
    if (imem_we !== 1'b1) begin failures++; $display("[TB] FAIL basic_last_we: got %b expected 1", imem_we); end
    if (imem_addr !== 14'd1) begin failures++; $display("[TB] FAIL basic_last_addr: got %h expected 1", imem_addr); end
    if (imem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL basic_last_data: got %h expected deadbeef", imem_wdata); end
    if (cpu_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL basic_hold_in_write: got %b expected 0", cpu_rst_n); end
    @(negedge clk);
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("[TB] FAIL basic_done: got %b expected 1", done); end
    if (cpu_rst_n !== 1'b1) begin failures++; $display("[TB] FAIL basic_release: got %b expected 1", cpu_rst_n); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle: got %b expected 0", busy); end
    if (imem_addr !== cpu_imem_addr) begin failures++; $display("[TB] FAIL basic_mux_back: got %h expected %h", imem_addr, cpu_imem_addr); end
    @(negedge clk);
    checks += 8;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
    if (wr_total - wbase !== 2) begin failures++; $display("[TB] FAIL basic_write_count: got %0d expected 2", wr_total - wbase); end
    if (wr_addr[wbase] !== 14'd0) begin failures++; $display("[TB] FAIL basic_addr0: got %h expected 0", wr_addr[wbase]); end
    if (wr_data[wbase] !== 32'h1234_5678) begin failures++; $display("[TB] FAIL basic_data0: got %h expected 12345678", wr_data[wbase]); end
    if (wr_addr[wbase+1] !== 14'd1) begin failures++; $display("[TB] FAIL basic_addr1: got %h expected 1", wr_addr[wbase+1]); end
    if (done_total - dbase !== 1) begin failures++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_total - dbase); end
    if (rst_viol !== 0) begin failures++; $display("[TB] FAIL basic_cpu_released_in_load: got %0d expected 0", rst_viol); end
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_zero_length();
    int wbase;
    wbase = wr_total;
    start_load();
    send_word(32'd0);
    @(negedge clk);
    checks += 5;
    if (done !== 1'b1) begin failures++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL zero_busy: got %b expected 0", busy); end
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL zero_err: got %b expected 0", err); end
    if (cpu_rst_n !== 1'b1) begin failures++; $display("[TB] FAIL zero_release: got %b expected 1", cpu_rst_n); end
    if (wr_total - wbase !== 0) begin failures++; $display("[TB] FAIL zero_writes: got %0d expected 0", wr_total - wbase); end
  endtask

  task automatic test_oversize();
    int wbase;
    wbase = wr_total;
    start_load();
    send_word(32'd16385);
    @(negedge clk);
    checks += 4;
    if (err !== 1'b1) begin failures++; $display("[TB] FAIL over_err: got %b expected 1", err); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL over_busy: got %b expected 0", busy); end
    if (cpu_rst_n !== 1'b1) begin failures++; $display("[TB] FAIL over_release: got %b expected 1", cpu_rst_n); end
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL over_done: got %b expected 0", done); end
    send_word(32'hAABB_CCDD);
    repeat (3) @(negedge clk);
    checks += 2;
    if (wr_total - wbase !== 0) begin failures++; $display("[TB] FAIL over_writes: got %0d expected 0", wr_total - wbase); end
    if (err !== 1'b1) begin failures++; $display("[TB] FAIL over_err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_timeout();
    int wbase;
    int dbase;
    wbase = wr_total;
    dbase = done_total;
    start_load();
    checks++;
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_err_cleared: got %b expected 0", err); end
    send_word(32'd3);
    send_word(32'h4433_2211);
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (14) @(negedge clk);
    checks += 2;
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_early_err: got %b expected 0", err); end
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL tmo_early_busy: got %b expected 1", busy); end
    repeat (3) @(negedge clk);
    checks += 7;
    if (err !== 1'b1) begin failures++; $display("[TB] FAIL tmo_err: got %b expected 1", err); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL tmo_busy: got %b expected 0", busy); end
    if (cpu_rst_n !== 1'b1) begin failures++; $display("[TB] FAIL tmo_release: got %b expected 1", cpu_rst_n); end
    if (wr_total - wbase !== 1) begin failures++; $display("[TB] FAIL tmo_writes: got %0d expected 1", wr_total - wbase); end
    if (wr_addr[wbase] !== 14'd0) begin failures++; $display("[TB] FAIL tmo_addr: got %h expected 0", wr_addr[wbase]); end
    if (wr_data[wbase] !== 32'h4433_2211) begin failures++; $display("[TB] FAIL tmo_data: got %h expected 44332211", wr_data[wbase]); end
    if (done_total - dbase !== 0) begin failures++; $display("[TB] FAIL tmo_done: got %0d expected 0", done_total - dbase); end
  endtask

  task automatic test_run_mux();
    int wbase;
    int bad;
    wbase = wr_total;
    bad = 0;
    cpu_imem_addr = 14'h123;
    for (int i = 0; i < 24; i++) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      @(negedge clk);
      checks++;
      if (imem_addr !== 14'h123) begin failures++; $display("[TB] FAIL run_mux_addr: got %h expected 123", imem_addr); end
    end
    rx_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (wr_total - wbase !== 0) begin failures++; $display("[TB] FAIL run_no_write: got %0d expected 0", wr_total - wbase); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL run_stays_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back_start();
    int wbase;
    wbase = wr_total;
    start_load();
    send_word(32'd1);
    send_byte(8'hC3);
    send_byte(8'hB2);
    start_load();
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL restart_busy: got %b expected 1", busy); end
    if (cpu_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL restart_hold: got %b expected 0", cpu_rst_n); end
    send_byte(8'hA1);
    send_byte(8'h90);
    repeat (3) @(negedge clk);
    checks += 4;
    if (wr_total - wbase !== 1) begin failures++; $display("[TB] FAIL restart_writes: got %0d expected 1", wr_total - wbase); end
    if (wr_addr[wbase] !== 14'd0) begin failures++; $display("[TB] FAIL restart_addr: got %h expected 0", wr_addr[wbase]); end
    if (wr_data[wbase] !== 32'h90A1_B2C3) begin failures++; $display("[TB] FAIL restart_data: got %h expected 90a1b2c3", wr_data[wbase]); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL restart_finish: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_load();
    int wbase;
    wbase = wr_total;
    cpu_imem_addr = 14'h055;
    start_load();
    send_word(32'd4);
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    repeat (2) @(negedge clk);
    checks += 2;
    if (wr_total - wbase !== 2) begin failures++; $display("[TB] FAIL rstmid_writes: got %0d expected 2", wr_total - wbase); end
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    if (cpu_rst_n !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_cpu_rst_n: got %b expected 0", cpu_rst_n); end
    if (err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_err: got %b expected 0", err); end
    if (imem_we !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_we: got %b expected 0", imem_we); end
    if (imem_addr !== 14'h055) begin failures++; $display("[TB] FAIL rstmid_mux: got %h expected 055", imem_addr); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_rst_n !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_release: got %b expected 1", cpu_rst_n); end
  endtask

  initial begin
    rst           = 1'b0;
    start_pg      = 1'b0;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    cpu_imem_addr = 14'h2A5;
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_zero_length();
    test_oversize();
    test_timeout();
    test_run_mux();
    test_back_to_back_start();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_load_ctrl.md
# prog_load_ctrl

Program-load controller that shares the instruction-memory write/address port between the running CPU and the UART boot path. On a `start_pg` request it holds the CPU in reset, takes a length-prefixed byte stream from the UART receiver, packs it into 32-bit little-endian words and writes them to consecutive instruction-memory words from address 0. When the load finishes or aborts, it releases the CPU, which restarts at PC 0.

## Interface
- `ADDR_W`, 14: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT`, 2_000_000: idle clock cycles without `rx_valid` before an in-progress load aborts.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `start_pg`  in  1  programming request, level; a rising edge is the event (already synchronised/debounced upstream).
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `cpu_imem_addr`  in  ADDR_W  CPU fetch word address.
- `cpu_rst_n`  out  1  0 holds the CPU/PC in reset.
- `imem_addr`  out  ADDR_W  address to instruction memory (arbitrated).
- `imem_we`  out  1  write strobe, one cycle per word.
- `imem_wdata`  out  32  word to write.
- `busy`  out  1  high in LEN or DATA state.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky error: timeout or oversize length.

## Operation
- States: RUN, LEN, DATA.
- Reset (`rst`=0 at a clock edge):
  - state=RUN; `cpu_rst_n`=0, `imem_we`=0, `imem_wdata`=0, `done`=0, `err`=0; byte, word and idle counters cleared; `start_pg` edge register cleared.
  - `cpu_rst_n` goes to 1 on the first edge after `rst` returns high.
- RUN:
  - `imem_addr`=`cpu_imem_addr` (combinational mux); `rx_valid` ignored.
  - `start_pg` rising edge → LEN. That edge: `cpu_rst_n`←0, `err`←0, counters cleared.
- LEN:
  - Collect 4 bytes LSB first into 32-bit word count N.
  - After the 4th byte, N=0 → RUN with `done` pulse.
  - N > 2^ADDR_W → RUN with `err`←1 and nothing written.
  - Otherwise → DATA.
- DATA:
  - Bytes pack LSB first: byte k of a word goes to bits [8k+7:8k].
  - After the 4th byte, `imem_we`=1 for one cycle with `imem_wdata`=packed word and `imem_addr`=word index (0,1,2,…). The index then increments.
  - After write number N → RUN, `done` pulse, `cpu_rst_n`←1.
- Timeout (LEN/DATA):
  - The idle counter resets on every `rx_valid` and increments otherwise.
  - When it reaches TIMEOUT → RUN, `err`←1, `cpu_rst_n`←1. Words already written stay written; a partial word is discarded.
- `start_pg` edges during LEN/DATA are ignored. `err` persists in RUN until the next accepted `start_pg` edge.
- Word-index arithmetic: ADDR_W bits, no wrap is reachable because N ≤ 2^ADDR_W is enforced.

## Timing
- `rx_valid` may assert on consecutive cycles; every strobe is accepted (no back-pressure).
- `imem_we` rises one cycle after the edge sampling the word's 4th byte, and lasts exactly one cycle.
- The final write, the RUN transition, the `done` pulse and `cpu_rst_n`=1 all occur on the same edge after the write cycle. The CPU's first fetch after that edge is at address 0.
- `imem_addr` is the loader's registered index whenever state≠RUN, so the CPU fetch address never reaches memory during a load.
- `busy`, `cpu_rst_n`, `done` and `err` are registered outputs.
- If reset asserts mid-load, the load is abandoned at once and the reset values above apply.

## Structure
- Shared package `prog_load_pkg`:
  - state enum (RUN/LEN/DATA);
  - `BYTES_PER_WORD`=4;
  - default `ADDR_W`/`TIMEOUT`.
- Sub-module `byte_packer`: 2-bit lane counter plus 32-bit shift/insert register, with outputs `word` and `word_valid`. It is shared by the LEN and DATA phases and has a clear input.
- The FSM, idle counter, word-index counter and the address mux live in `prog_load_ctrl`.

## Test plan
- Reset, then `start_pg` edge, stream 00 00 00 02 reversed (02 00 00 00) then 78 56 34 12 EF BE AD DE, one byte per cycle → writes 0x12345678@0 and 0xDEADBEEF@1, a `done` pulse, `cpu_rst_n` low throughout and high after the last write.
- Length 0 → back to RUN with `done`, no `imem_we`, `err`=0.
- Length 2^ADDR_W+1 → `err`=1, no writes, RUN, `cpu_rst_n`=1.
- TIMEOUT=16, length 3, send 6 bytes then stop → exactly 1 write @0, `err`=1 after 16 idle cycles, RUN.
- In RUN, drive `cpu_imem_addr`=0x123 and random `rx_valid` → `imem_addr`=0x123 and never `imem_we`. A second `start_pg` edge during a load changes nothing.
- Assert `rst` during DATA, after 2 words → next cycle state RUN, `cpu_rst_n`=0, `err`=0. The following cycle `cpu_rst_n`=1.
